// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller_pkg
// Purpose  : Shared definitions for the interrupt controller. This file holds
//            the controller FSM state encoding, the default number of sources
//            and the device index constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

  // Default number of interrupt sources: timer, keys, switches, spare.
  localparam int NSRC_DEFAULT = 4;

  // Device index constants. A lower index has a higher priority.
  localparam int DEV_TIMER = 0;
  localparam int DEV_KEY   = 1;
  localparam int DEV_SW    = 2;
  localparam int DEV_SPARE = 3;

  // States of the controller FSM.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage : interrupt_controller_pkg
`default_nettype wire

// File: rtl/interrupt_controller_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder
// Purpose  : Fixed-priority encoder. It returns the index of the lowest set
//            request bit, so bit 0 has the highest priority.
// Ports    : req_i   [N-1:0]  request vector
//            idx_o   [IW-1:0] index of the winning request
//            valid_o          high when any request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // The loop scans from the top index down. Each set bit overwrites the
  // previous result, so the lowest set index is the one that remains.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule : priority_encoder
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Non-nesting interrupt controller. Each device request is
//            edge-detected into a pending bit. The controller picks the
//            lowest-index pending source and requests an interrupt from the
//            pipeline. It then tracks the handler until RETI.
// Ports    : clk                 clock, rising edge
//            reset               asynchronous active-high reset
//            devIrq    [NSRC-1:0] level interrupt requests from the devices
//            ieIn                global interrupt enable (PCS bit 0)
//            intAck              pulse: the pipeline took the interrupt
//            isReti              pulse: a RETI instruction committed
//            inta                interrupt request to the pipeline
//            idn       [DBITS-1:0] index of the requested/serviced source
//            devAck    [NSRC-1:0] one-hot pulse that clears the device request
//            inService           high while a handler runs
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int NSRC  = NSRC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  devIrq,
  input  logic             ieIn,
  input  logic             intAck,
  input  logic             isReti,
  output logic             inta,
  output logic [DBITS-1:0] idn,
  output logic [NSRC-1:0]  devAck,
  output logic             inService
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_e          state_q;
  logic [NSRC-1:0] prevIrq_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] devAck_q;
  logic [IW-1:0]   idx_q;
  logic            inta_q;
  logic            inService_q;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [IW-1:0]   win_idx;
  logic            win_valid;

  assign rise = devIrq & ~prevIrq_q;

  // A request is cleared only when the acknowledge is accepted in REQ.
  // The new rise is ORed in after the clear, so a rise on the same edge
  // keeps the pending bit set.
  always_comb begin
    clr = '0;
    if (state_q == ST_REQ && intAck) begin
      clr[idx_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  priority_encoder #(
    .N  (NSRC),
    .IW (IW)
  ) u_prio (
    .req_i   (pending_q),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // The FSM registers all of its outputs. inta, inService and devAck are
  // set on the same edge as the state change that they reflect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prevIrq_q   <= '0;
      pending_q   <= '0;
      idx_q       <= '0;
      inta_q      <= 1'b0;
      devAck_q    <= '0;
      inService_q <= 1'b0;
    end else begin
      prevIrq_q <= devIrq;
      pending_q <= pending_d;
      devAck_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          // Arbitration happens only here. idx_q is held until the
          // controller comes back to IDLE.
          if (win_valid && ieIn) begin
            state_q <= ST_REQ;
            idx_q   <= win_idx;
            inta_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (intAck) begin
            state_q     <= ST_SERVICE;
            inta_q      <= 1'b0;
            inService_q <= 1'b1;
            devAck_q    <= clr;
          end else if (!ieIn) begin
            // The request is withdrawn and the pending bit stays set.
            state_q <= ST_IDLE;
            inta_q  <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (isReti) begin
            state_q     <= ST_IDLE;
            inService_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          inta_q      <= 1'b0;
          inService_q <= 1'b0;
        end
      endcase
    end
  end

  assign inta      = inta_q;
  assign inService = inService_q;
  assign devAck    = devAck_q;
  assign idn       = DBITS'(idx_q);

endmodule : interrupt_controller
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Scoreboard bench for interrupt_controller. The stimulus process
//            drives inputs and pushes the responses that a reference model
//            predicts. A monitor process pops these and compares them with
//            the DUT outputs after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

  localparam int NSRC  = 4;
  localparam int DBITS = 32;

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic [NSRC-1:0]  devIrq = '0;
  logic             ieIn   = 1'b0;
  logic             intAck = 1'b0;
  logic             isReti = 1'b0;
  logic             inta;
  logic [DBITS-1:0] idn;
  logic [NSRC-1:0]  devAck;
  logic             inService;

  interrupt_controller #(
    .DBITS (DBITS),
    .NSRC  (NSRC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .devIrq    (devIrq),
    .ieIn      (ieIn),
    .intAck    (intAck),
    .isReti    (isReti),
    .inta      (inta),
    .idn       (idn),
    .devAck    (devAck),
    .inService (inService)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             inta;
    logic [DBITS-1:0] idn;
    logic [NSRC-1:0]  ack;
    logic             svc;
    logic [NSRC-1:0]  pend;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // ---------------- reference model ----------------
  // The model state is the phase of the interrupt: 0 = idle, 1 = requested
  // and 2 = handler running. It also keeps the set of pending sources.
  int              m_phase;
  int              m_idn;
  logic [NSRC-1:0] m_prev;
  logic [NSRC-1:0] m_pend;
  logic [NSRC-1:0] m_ack;

  function automatic int lowest_set(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idn = 0; m_prev = '0; m_pend = '0; m_ack = '0;
  endtask

  task automatic model_clock(input logic [NSRC-1:0] d, input logic ie,
                             input logic ack, input logic reti);
    logic [NSRC-1:0] newly;
    logic [NSRC-1:0] served;
    logic [NSRC-1:0] one;
    newly  = d & ~m_prev;
    served = '0;
    one    = 1;
    m_ack  = '0;
    if (m_phase == 0) begin
      if (m_pend != 0 && ie) begin m_phase = 1; m_idn = lowest_set(m_pend); end
    end else if (m_phase == 1) begin
      if (ack) begin
        served  = one << m_idn;
        m_ack   = served;
        m_phase = 2;
      end else if (!ie) begin
        m_phase = 0;
      end
    end else begin
      if (reti) m_phase = 0;
    end
    m_pend = (m_pend & ~served) | newly;
    m_prev = d;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.inta = (m_phase == 1);
    e.idn  = DBITS'(m_idn);
    e.ack  = m_ack;
    e.svc  = (m_phase == 2);
    e.pend = m_pend;
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic [NSRC-1:0] d, input logic ie,
                      input logic ack, input logic reti);
    @(negedge clk);
    reset = r; devIrq = d; ieIn = ie; intAck = ack; isReti = reti;
    if (r) model_reset();
    else   model_clock(d, ie, ack, reti);
    sb.push_back(model_out());
  endtask

  // Assert reset between edges and check that the outputs clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (inta !== 1'b0 || inService !== 1'b0 || devAck !== '0 ||
        dut.pending_q !== '0 || idn !== '0) begin
      errors++;
      $display("FAIL async_reset: got inta=%0b inService=%0b devAck=%b pending=%b idn=%0d, want all zero",
               inta, inService, devAck, dut.pending_q, idn);
    end
    model_reset();
    sb.push_back(model_out());
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  exp_t mon_a;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e      = sb.pop_front();
        mon_a.inta = inta;
        mon_a.idn  = idn;
        mon_a.ack  = devAck;
        mon_a.svc  = inService;
        mon_a.pend = dut.pending_q;
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL outputs @%0t: got inta=%0b idn=%0d devAck=%b inService=%0b pending=%b, want inta=%0b idn=%0d devAck=%b inService=%0b pending=%b",
                   $time, mon_a.inta, mon_a.idn, mon_a.ack, mon_a.svc, mon_a.pend,
                   mon_e.inta, mon_e.idn, mon_e.ack, mon_e.svc, mon_e.pend);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  logic [NSRC-1:0] rd;
  int              nres;
  initial begin
    model_reset();
    // Source 0 is held high through reset release. It registers one rise.
    step(1, 4'b0001, 1, 0, 0);
    step(1, 4'b0001, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);
    // Single source: key.
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 1);
    step(0, 4'b0000, 1, 0, 0);
    // Priority: sources 0 and 3 rise together.
    step(0, 4'b1001, 1, 0, 0);
    step(0, 4'b1001, 1, 0, 0);
    step(0, 4'b1001, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);
    step(0, 4'b0000, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);
    // Masked source 2, then enabled.
    step(0, 4'b0100, 0, 0, 0);
    step(0, 4'b0100, 0, 0, 0);
    step(0, 4'b0100, 0, 0, 0);
    step(0, 4'b0000, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);
    // Withdraw: enable drops while the controller is in REQ.
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0010, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);
    // Collision: source 0 rises again on its own acknowledge edge.
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0000, 1, 0, 0);
    step(0, 4'b0001, 1, 1, 0);
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 1);
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0001, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);
    // Stray acknowledge and RETI while idle.
    step(0, 4'b0000, 1, 1, 1);
    step(0, 4'b0000, 1, 0, 0);
    // Reset while a handler runs.
    step(0, 4'b0100, 1, 0, 0);
    step(0, 4'b0100, 1, 0, 0);
    step(0, 4'b0100, 1, 1, 0);
    async_reset();
    step(1, 4'b0100, 1, 0, 0);
    step(0, 4'b0100, 1, 0, 0);
    step(0, 4'b0100, 1, 0, 0);
    step(0, 4'b0000, 1, 1, 0);
    step(0, 4'b0000, 1, 0, 1);

    // Randomized traffic, with an occasional reset during service.
    rd   = '0;
    nres = 0;
    for (int k = 0; k < 600; k++) begin
      if (m_phase == 2 && nres < 3 && $urandom_range(0, 15) == 0) begin
        async_reset();
        nres++;
        step(1, rd, 1, 0, 0);
      end else begin
        rd = rd ^ NSRC'($urandom_range(0, 15) & $urandom_range(0, 15));
        step(0, rd, $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0);
      end
    end
    step(0, 4'b0000, 1, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_interrupt_controller
`default_nettype wire
